// File: rtl/arbiter_wrr.sv
// Weighted round-robin arbiter with registered one-hot grant and per-port burst credit.
// Optional port lock is compiled in with ARB_WRR_LOCK_EN.
module arbiter_wrr #(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned WEIGHT_W  = 4,
  parameter int unsigned MODE      = 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS-1:0]            request,
  input  logic [NUM_PORTS*WEIGHT_W-1:0]   weights,
`ifdef ARB_WRR_LOCK_EN
  input  logic                            lock,
`endif
  output logic [NUM_PORTS-1:0]            grant,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_idx,
  output logic                            active
);

  localparam int unsigned IDX_W = $clog2(NUM_PORTS);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 state_q, state_n;
  logic [NUM_PORTS-1:0]   grant_q, grant_n;
  logic [IDX_W-1:0]       idx_q, idx_n;
  logic [IDX_W-1:0]       ptr_q, ptr_n;
  logic [WEIGHT_W-1:0]    credit_q, credit_n;
  logic                   active_q, active_n;

  logic [WEIGHT_W-1:0]    w_arr [NUM_PORTS];
  logic                   rr_found;
  logic [IDX_W-1:0]       rr_idx;
  logic                   fp_found;
  logic [IDX_W-1:0]       fp_idx;
  logic                   lock_hold;
  logic                   owner_keeps;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_weights
    assign w_arr[i] = weights[i*WEIGHT_W +: WEIGHT_W];
  end

`ifdef ARB_WRR_LOCK_EN
  assign lock_hold = lock;
`else
  assign lock_hold = 1'b0;
`endif

  // Round-robin search: walk downward from ptr, wrapping modulo NUM_PORTS.
  always_comb begin : rr_search
    logic [IDX_W-1:0] c;
    rr_found = 1'b0;
    rr_idx   = '0;
    c        = '0;
    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
      c = IDX_W'((32'(ptr_q) + NUM_PORTS - k) % NUM_PORTS);
      if (!rr_found && request[c]) begin
        rr_found = 1'b1;
        rr_idx   = c;
      end
    end
  end

  // Fixed priority: the highest-index requester wins.
  always_comb begin : fp_search
    fp_found = 1'b0;
    fp_idx   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (request[i]) begin
        fp_found = 1'b1;
        fp_idx   = IDX_W'(i);
      end
    end
  end

  // Lock holds the owner regardless of remaining credit; otherwise credit must exceed one.
  assign owner_keeps = (state_q == OWNED) && request[idx_q] &&
                       (lock_hold || (credit_q > WEIGHT_W'(1)));

  always_comb begin : next_state
    state_n  = state_q;
    grant_n  = grant_q;
    idx_n    = idx_q;
    ptr_n    = ptr_q;
    credit_n = credit_q;
    if (MODE == 0) begin
      if (fp_found) begin
        state_n = OWNED;
        idx_n   = fp_idx;
        grant_n = NUM_PORTS'(1) << fp_idx;
      end else begin
        state_n = IDLE;
        grant_n = '0;
      end
    end else if (owner_keeps) begin
      if (!lock_hold) begin
        credit_n = credit_q - WEIGHT_W'(1);
      end
    end else if (rr_found) begin
      state_n  = OWNED;
      idx_n    = rr_idx;
      grant_n  = NUM_PORTS'(1) << rr_idx;
      credit_n = (w_arr[rr_idx] == '0) ? WEIGHT_W'(1) : w_arr[rr_idx];
      ptr_n    = IDX_W'((32'(rr_idx) + NUM_PORTS - 1) % NUM_PORTS);
    end else begin
      state_n = IDLE;
      grant_n = '0;
    end
    active_n = |grant_n;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      idx_q    <= '0;
      ptr_q    <= IDX_W'(NUM_PORTS - 1);
      credit_q <= '0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      grant_q  <= grant_n;
      idx_q    <= idx_n;
      ptr_q    <= ptr_n;
      credit_q <= credit_n;
      active_q <= active_n;
    end
  end

  assign grant     = grant_q;
  assign grant_idx = idx_q;
  assign active    = active_q;

  a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
  a_active_match:  assert property (@(posedge clk) disable iff (!rst_n) active_q == (|grant_q));

endmodule

// File: tb/tb_arbiter_wrr.sv
// Bench for arbiter_wrr: vector table, directed corner sequences, random run against a reference model.
module tb_arbiter_wrr;

  logic        clk;
  logic        rst_n;
  logic [3:0]  request, request0;
  logic [15:0] weights;
  logic [15:0] weights0;
  logic        lock;
  logic [3:0]  grant, grant0;
  logic [1:0]  grant_idx, grant_idx0;
  logic        active, active0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  arbiter_wrr #(.NUM_PORTS(4), .WEIGHT_W(4), .MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .request(request), .weights(weights),
`ifdef ARB_WRR_LOCK_EN
    .lock(lock),
`endif
    .grant(grant), .grant_idx(grant_idx), .active(active)
  );

  arbiter_wrr #(.NUM_PORTS(4), .WEIGHT_W(4), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .request(request0), .weights(weights0),
`ifdef ARB_WRR_LOCK_EN
    .lock(lock),
`endif
    .grant(grant0), .grant_idx(grant_idx0), .active(active0)
  );

  typedef struct packed {
    logic       sel;
    logic [3:0] g;
    logic [1:0] i;
  } exp_t;

  typedef struct {
    logic        rst;
    logic [15:0] w;
    logic [3:0]  req;
    logic [3:0]  g;
    logic [1:0]  i;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;

  int         m_own, m_ptr, m_credit;
  logic [1:0] m_idx, m0_idx;

  task automatic add(input logic r, input logic [15:0] w, input logic [3:0] req,
                     input logic [3:0] g, input logic [1:0] i);
    vec_t v;
    v.rst = r; v.w = w; v.req = req; v.g = g; v.i = i;
    vecs.push_back(v);
  endtask

  task automatic expect_out(input logic sel, input logic [3:0] g, input logic [1:0] i);
    exp_t e;
    e.sel = sel; e.g = g; e.i = i;
    sb.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [3:0] ag, input logic [1:0] ai, input logic aa,
                     input logic [3:0] eg, input logic [1:0] ei);
    total++;
    if (ag !== eg || ai !== ei || aa !== (|eg)) begin
      bad++;
      $display("FAIL %s: grant=%b idx=%0d active=%b, required grant=%b idx=%0d active=%b",
               name, ag, ai, aa, eg, ei, |eg);
    end
  endtask

  // Starts and ends on a falling edge; inputs change here, outputs are checked 1 after the rising edge.
  task automatic step(input string name, input logic [3:0] r, input logic [3:0] r0);
    exp_t e;
    request  = r;
    request0 = r0;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.sel) cmp({name, "_m0"}, grant0, grant_idx0, active0, e.g, e.i);
      else       cmp(name, grant, grant_idx, active, e.g, e.i);
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    #1;
    cmp({name, "_rst"}, grant, grant_idx, active, 4'b0000, 2'd0);
    cmp({name, "_rst_m0"}, grant0, grant_idx0, active0, 4'b0000, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [15:0] w,
                            output logic [3:0] eg, output logic [1:0] ei);
    int f;
    f = -1;
    if (m_own >= 0 && r[m_own[1:0]] && m_credit > 1) begin
      m_credit--;
    end else begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_ptr - k + 4) % 4;
        if (f < 0 && r[c[1:0]]) f = c;
      end
      if (f >= 0) begin
        m_own    = f;
        m_idx    = f[1:0];
        m_credit = int'((w >> (4 * f)) & 16'h000F);
        if (m_credit == 0) m_credit = 1;
        m_ptr    = (f + 3) % 4;
      end else begin
        m_own = -1;
      end
    end
    eg = (m_own >= 0) ? (4'b0001 << m_own[1:0]) : 4'b0000;
    ei = m_idx;
  endtask

  initial begin
    logic [3:0] r, r0, eg, eg0;
    logic [1:0] ei;
    rst_n    = 1'b0;
    request  = '0;
    request0 = '0;
    weights  = '0;
    weights0 = '0;
    lock     = 1'b0;

    // Reset with all requesting, then first grant to port 3.
    add(1, 16'h1111, 4'b1111, 4'b1000, 2'd3);
    // Weights 3,1,1,2 on ports 3..0, all requesting.
    add(1, 16'h3112, 4'b1111, 4'b1000, 2'd3);
    for (int n = 0; n < 13; n++) begin
      logic [1:0] s;
      int seq [7] = '{3, 3, 3, 2, 1, 0, 0};
      s = seq[(n + 1) % 7][1:0];
      add(0, 16'h3112, 4'b1111, 4'b0001 << s, s);
    end
    // Sole requester is re-granted without a gap.
    add(1, 16'h0200, 4'b0100, 4'b0100, 2'd2);
    for (int n = 0; n < 5; n++) add(0, 16'h0200, 4'b0100, 4'b0100, 2'd2);
    // Owner drops request: immediate handover, then idle keeps grant_idx.
    add(1, 16'h4000, 4'b1010, 4'b1000, 2'd3);
    add(0, 16'h4000, 4'b0010, 4'b0010, 2'd1);
    add(0, 16'h4000, 4'b0000, 4'b0000, 2'd1);
    add(0, 16'h4000, 4'b0010, 4'b0010, 2'd1);
    // Zero weights behave as one and the pointer wraps 0 -> 3.
    add(1, 16'h0000, 4'b1111, 4'b1000, 2'd3);
    add(0, 16'h0000, 4'b1111, 4'b0100, 2'd2);
    add(0, 16'h0000, 4'b1111, 4'b0010, 2'd1);
    add(0, 16'h0000, 4'b1111, 4'b0001, 2'd0);
    add(0, 16'h0000, 4'b1111, 4'b1000, 2'd3);

    @(negedge clk);
    foreach (vecs[n]) begin
      if (vecs[n].rst) begin
        weights = vecs[n].w;
        request = vecs[n].req;
        do_reset($sformatf("vec%0d", n));
      end
      expect_out(1'b0, vecs[n].g, vecs[n].i);
      step($sformatf("vec%0d", n), vecs[n].req, 4'b0000);
    end

    // Fixed-priority instance re-evaluates every edge.
    request = '0;
    do_reset("mode0");
    expect_out(1'b1, 4'b0100, 2'd2); step("mode0_a", 4'b0000, 4'b0101);
    expect_out(1'b1, 4'b1000, 2'd3); step("mode0_b", 4'b0000, 4'b1101);
    expect_out(1'b1, 4'b0001, 2'd0); step("mode0_c", 4'b0000, 4'b0001);
    expect_out(1'b1, 4'b0000, 2'd0); step("mode0_d", 4'b0000, 4'b0000);

`ifdef ARB_WRR_LOCK_EN
    // Lock holds the owner past its credit; release hands over on the next edge.
    weights = 16'h0001;
    request = '0;
    do_reset("lock");
    lock = 1'b1;
    expect_out(1'b0, 4'b0001, 2'd0); step("lock_0", 4'b0001, 4'b0000);
    for (int n = 1; n < 5; n++) begin
      expect_out(1'b0, 4'b0001, 2'd0); step($sformatf("lock_%0d", n), 4'b0101, 4'b0000);
    end
    lock = 1'b0;
    expect_out(1'b0, 4'b0100, 2'd2); step("lock_rel", 4'b0101, 4'b0000);
    do_reset("lock_mid");
`endif

    // Random traffic against the reference models.
    lock    = 1'b0;
    request = '0;
    do_reset("rand");
    m_own = -1; m_ptr = 3; m_credit = 0; m_idx = 2'd0; m0_idx = 2'd0;
    for (int n = 0; n < 200; n++) begin
      if (n % 8 == 0) begin
        weights  = 16'($urandom);
        weights0 = 16'($urandom);
      end
      r  = 4'($urandom_range(0, 15));
      r0 = 4'($urandom_range(0, 15));
      model_step(r, weights, eg, ei);
      expect_out(1'b0, eg, ei);
      eg0 = 4'b0000;
      for (int i = 0; i < 4; i++) begin
        if (r0[i]) begin
          eg0    = 4'b0001 << i;
          m0_idx = 2'(i);
        end
      end
      expect_out(1'b1, eg0, m0_idx);
      step($sformatf("rand%0d", n), r, r0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
